alu_resp_router: RTL and testbench
==================================

# alu_resp_router

Response-side counterpart of the calc1 priority/dispatch logic. It accepts completed results from ALU1 (add/sub) and ALU2 (shift), steers each result to the requesting port's response and data outputs, and serializes collisions through a one-entry skid buffer with stall back to the ALUs. It tracks outstanding issues per port from the dispatch side's issue strobes and flags protocol violations.

## Interface
Parameters:
- DATA_W, 32, result data width
- PORTS, 4, number of requester ports; fixed at 4 (req_id is 2 bits)

Ports:
- c_clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- iss1_vld, iss2_vld  in  1  dispatch side issued a command to ALU1 / ALU2 this cycle
- iss1_req_id, iss2_req_id  in  2  port of the issued command
- alu1_vld, alu2_vld  in  1  ALU result valid, single-cycle strobe
- alu1_req_id, alu2_req_id  in  2  destination port of the result
- alu1_resp, alu2_resp  in  2  response code: 01 success, 10 overflow/invalid; 00 and 11 illegal while vld
- alu1_data, alu2_data  in  DATA_W  result data
- resp_stall  out  1  ALUs must not assert vld while this is high
- out_resp1..out_resp4  out  2 each  per-port response, non-zero for exactly one cycle per result
- out_data1..out_data4  out  DATA_W each  per-port data, valid only while matching out_resp is non-zero, otherwise 0
- proto_err  out  1  sticky protocol-violation flag
- idle  out  1  no outstanding issues and skid buffer empty

## Operation
- Reset (async assert, sync-safe deassert): all out_resp and out_data = 0, resp_stall = 0, proto_err = 0, skid empty, all outstanding counters = 0, idle = 1.
- Normal delivery: alu*_vld with resp R, data D, id P in cycle N sets out_respP = R, out_dataP = D in cycle N+1, and clears them in N+2 unless another result arrives.
- Different-port simultaneous results: both are delivered in N+1.
- Same-port collision (alu1_vld and alu2_vld with equal req_id): ALU1 is delivered in N+1, ALU2 is captured in the skid and delivered in N+2.
- resp_stall = skid occupied (registered). Skid drains unconditionally one cycle after capture.
- vld asserted while resp_stall is high: the result is dropped and proto_err is set.
- vld with resp 00 or 11: the result is delivered as-is and proto_err is set.
- Outstanding counter per port, 2 bits, range 0..3:
  - +1 per issue strobe naming the port; two issues to the same port in one cycle add 2.
  - −1 per result delivered to out_resp.
  - Increment and decrement in the same cycle net out.
- Increment past 3 saturates at 3 and sets proto_err.
- Delivery to a port whose counter is 0 (after same-cycle increments) leaves the counter at 0, still drives the output, and sets proto_err.
- idle = all counters 0 and skid empty.
- proto_err clears only on reset.

## Timing
- Latency: ALU vld to out_resp is 1 cycle; 2 cycles for a skidded ALU2 result.
- resp_stall is high in exactly the cycle after a collision, so at most one stall cycle per collision.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-delivery or with the skid full: outputs go to 0 immediately and the skid contents are lost.

## Structure
- Shared package calc1_pkg:
  - RESP_NONE = 2'b00, RESP_OK = 2'b01, RESP_ERR = 2'b10
  - req_id_t (2-bit)
  - resp_t (2-bit)
  - result struct {resp, req_id, data}
- Sub-module: resp_port_ctr, instantiated ×4. It holds one outstanding counter with inc0/inc1/dec inputs, and produces the count plus overflow/underflow error pulses.

## Test plan
- Single result: iss1 to port 2, then alu1_vld, id 2, resp 01, data 0x0000_0005 -> out_resp2 = 01 and out_data2 = 5 for one cycle, counter back to 0, idle = 1.
- Different-port pair: alu1 to id 0 (data 7) and alu2 to id 3 (data 0x80) in the same cycle -> out_resp1 and out_resp4 both 01 in the next cycle, resp_stall stays 0.
- Same-port collision: both ALUs to id 1 (data 0xA, 0xB) -> out_data2 = 0xA in N+1, resp_stall = 1 in N+1, out_data2 = 0xB in N+2.
- Stall violation: alu1_vld asserted during resp_stall -> that result is never delivered, proto_err = 1.
- Counter errors: a result to a port with 0 outstanding -> proto_err = 1. In a separate run, 4 issues to port 0 with no results -> counter = 3, proto_err = 1.
- Reset mid-operation: assert reset_n = 0 with the skid full -> all outputs 0 asynchronously; after release, idle = 1 and no stale delivery appears.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared types and response codes for the calc1 dispatch/response datapath.
package calc1_pkg;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  localparam int unsigned CALC1_DATA_W = 32;

  typedef logic [1:0] req_id_t;
  typedef logic [1:0] resp_t;

  typedef struct packed {
    resp_t                   resp;
    req_id_t                 req_id;
    logic [CALC1_DATA_W-1:0] data;
  } result_t;

  function automatic logic resp_legal(resp_t r);
    return (r == RESP_OK) || (r == RESP_ERR);
  endfunction

endpackage

// File: rtl/resp_port_ctr.sv
// Per-port outstanding-issue counter, saturating 0..3, with overflow/underflow pulses.
module resp_port_ctr (
  input  logic       c_clk,
  input  logic       reset_n,
  input  logic       inc0,
  input  logic       inc1,
  input  logic       dec,
  output logic [1:0] count,
  output logic       ovf,
  output logic       udf
);

  logic [1:0] cnt_q, cnt_d;
  logic [2:0] sum;

  // Increments are applied first so a same-cycle issue can cover a delivery.
  always_comb begin
    sum = {1'b0, cnt_q} + {2'b00, inc0} + {2'b00, inc1};
    ovf = 1'b0;
    udf = 1'b0;
    if (dec) begin
      if (sum == 3'd0) udf = 1'b1;
      else             sum = sum - 3'd1;
    end
    if (sum > 3'd3) begin
      ovf   = 1'b1;
      cnt_d = 2'd3;
    end else begin
      cnt_d = sum[1:0];
    end
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 2'd0;
    else          cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/alu_resp_router.sv
// Routes ALU1/ALU2 results to per-port outputs; same-port collisions serialize via a skid entry.
module alu_resp_router
  import calc1_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PORTS  = 4
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic              iss1_vld,
  input  logic [1:0]        iss1_req_id,
  input  logic              iss2_vld,
  input  logic [1:0]        iss2_req_id,
  input  logic              alu1_vld,
  input  logic [1:0]        alu1_req_id,
  input  logic [1:0]        alu1_resp,
  input  logic [DATA_W-1:0] alu1_data,
  input  logic              alu2_vld,
  input  logic [1:0]        alu2_req_id,
  input  logic [1:0]        alu2_resp,
  input  logic [DATA_W-1:0] alu2_data,
  output logic              resp_stall,
  output logic [1:0]        out_resp1,
  output logic [1:0]        out_resp2,
  output logic [1:0]        out_resp3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4,
  output logic              proto_err,
  output logic              idle
);

  resp_t             resp_q [PORTS];
  resp_t             resp_d [PORTS];
  logic [DATA_W-1:0] data_q [PORTS];
  logic [DATA_W-1:0] data_d [PORTS];
  logic [PORTS-1:0]  dlv, ovf, udf;
  logic [1:0]        cnt [PORTS];

  logic              skid_vld_q, skid_vld_d;
  resp_t             skid_resp_q, skid_resp_d;
  req_id_t           skid_id_q, skid_id_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              err_q, err_d;
  logic              acc1, acc2, collide, cnt_zero;

  always_comb begin
    // While the skid drains, ALU strobes are protocol violations and are dropped.
    acc1    = alu1_vld & ~skid_vld_q;
    acc2    = alu2_vld & ~skid_vld_q;
    collide = acc1 & acc2 & (alu1_req_id == alu2_req_id);

    skid_vld_d  = collide;
    skid_resp_d = skid_resp_q;
    skid_id_d   = skid_id_q;
    skid_data_d = skid_data_q;
    if (collide) begin
      skid_resp_d = alu2_resp;
      skid_id_d   = alu2_req_id;
      skid_data_d = alu2_data;
    end

    for (int unsigned p = 0; p < PORTS; p++) begin
      dlv[p]    = 1'b0;
      resp_d[p] = RESP_NONE;
      data_d[p] = '0;
      if (skid_vld_q && skid_id_q == req_id_t'(p)) begin
        dlv[p]    = 1'b1;
        resp_d[p] = skid_resp_q;
        data_d[p] = skid_data_q;
      end else if (acc1 && alu1_req_id == req_id_t'(p)) begin
        dlv[p]    = 1'b1;
        resp_d[p] = alu1_resp;
        data_d[p] = alu1_data;
      end else if (acc2 && !collide && alu2_req_id == req_id_t'(p)) begin
        dlv[p]    = 1'b1;
        resp_d[p] = alu2_resp;
        data_d[p] = alu2_data;
      end
      if (resp_d[p] == RESP_NONE) data_d[p] = '0;
    end

    err_d = err_q
          | (skid_vld_q & (alu1_vld | alu2_vld))
          | (acc1 & ~resp_legal(alu1_resp))
          | (acc2 & ~resp_legal(alu2_resp))
          | (|ovf) | (|udf);

    cnt_zero = 1'b1;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (cnt[p] != 2'd0) cnt_zero = 1'b0;
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_ctr
    resp_port_ctr u_ctr (
      .c_clk   (c_clk),
      .reset_n (reset_n),
      .inc0    (iss1_vld && iss1_req_id == req_id_t'(p)),
      .inc1    (iss2_vld && iss2_req_id == req_id_t'(p)),
      .dec     (dlv[p]),
      .count   (cnt[p]),
      .ovf     (ovf[p]),
      .udf     (udf[p])
    );
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        resp_q[p] <= RESP_NONE;
        data_q[p] <= '0;
      end
      skid_vld_q  <= 1'b0;
      skid_resp_q <= RESP_NONE;
      skid_id_q   <= '0;
      skid_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        resp_q[p] <= resp_d[p];
        data_q[p] <= data_d[p];
      end
      skid_vld_q  <= skid_vld_d;
      skid_resp_q <= skid_resp_d;
      skid_id_q   <= skid_id_d;
      skid_data_q <= skid_data_d;
      err_q       <= err_d;
    end
  end

  assign out_resp1  = resp_q[0];
  assign out_resp2  = resp_q[1];
  assign out_resp3  = resp_q[2];
  assign out_resp4  = resp_q[3];
  assign out_data1  = data_q[0];
  assign out_data2  = data_q[1];
  assign out_data3  = data_q[2];
  assign out_data4  = data_q[3];
  assign resp_stall = skid_vld_q;
  assign proto_err  = err_q;
  assign idle       = cnt_zero & ~skid_vld_q;

endmodule

// File: tb/tb_alu_resp_router.sv
// Randomized and directed bench for alu_resp_router against a queue-based reference model.
module tb_alu_resp_router;

  logic        c_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        iss1_vld, iss2_vld, alu1_vld, alu2_vld;
  logic [1:0]  iss1_req_id, iss2_req_id, alu1_req_id, alu2_req_id, alu1_resp, alu2_resp;
  logic [31:0] alu1_data, alu2_data;
  logic        resp_stall, proto_err, idle;
  logic [3:0][1:0]  out_resp;
  logic [3:0][31:0] out_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  resp;
    logic [1:0]  id;
    logic [31:0] data;
  } item_t;

  // Reference model state: what the outputs should show after the next edge.
  item_t       skq[$];
  int          m_cnt [4];
  logic [1:0]  m_resp [4];
  logic [31:0] m_data [4];
  bit          m_err;

  always #5 c_clk = ~c_clk;

  alu_resp_router #(.DATA_W(32), .PORTS(4)) dut (
    .c_clk       (c_clk),
    .reset_n     (reset_n),
    .iss1_vld    (iss1_vld),
    .iss1_req_id (iss1_req_id),
    .iss2_vld    (iss2_vld),
    .iss2_req_id (iss2_req_id),
    .alu1_vld    (alu1_vld),
    .alu1_req_id (alu1_req_id),
    .alu1_resp   (alu1_resp),
    .alu1_data   (alu1_data),
    .alu2_vld    (alu2_vld),
    .alu2_req_id (alu2_req_id),
    .alu2_resp   (alu2_resp),
    .alu2_data   (alu2_data),
    .resp_stall  (resp_stall),
    .out_resp1   (out_resp[0]),
    .out_resp2   (out_resp[1]),
    .out_resp3   (out_resp[2]),
    .out_resp4   (out_resp[3]),
    .out_data1   (out_data[0]),
    .out_data2   (out_data[1]),
    .out_data3   (out_data[2]),
    .out_data4   (out_data[3]),
    .proto_err   (proto_err),
    .idle        (idle)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [1:0] r);
    return r == 2'b01 || r == 2'b10;
  endfunction

  task automatic drive_idle();
    iss1_vld = 0; iss2_vld = 0; alu1_vld = 0; alu2_vld = 0;
    iss1_req_id = 0; iss2_req_id = 0; alu1_req_id = 0; alu2_req_id = 0;
    alu1_resp = 0; alu2_resp = 0; alu1_data = 0; alu2_data = 0;
  endtask

  task automatic model_reset();
    skq.delete();
    m_err = 0;
    for (int p = 0; p < 4; p++) begin
      m_cnt[p] = 0; m_resp[p] = 0; m_data[p] = 0;
    end
  endtask

  task automatic model_step();
    item_t del[$];
    item_t it;
    int inc [4];
    int dec [4];
    int sum;
    for (int p = 0; p < 4; p++) begin
      inc[p] = 0; dec[p] = 0; m_resp[p] = 0; m_data[p] = 0;
    end
    if (skq.size() != 0) begin
      del.push_back(skq.pop_front());
      if (alu1_vld || alu2_vld) m_err = 1;
    end else begin
      if (alu1_vld) begin
        it = '{alu1_resp, alu1_req_id, alu1_data};
        del.push_back(it);
        if (!legal(alu1_resp)) m_err = 1;
      end
      if (alu2_vld) begin
        it = '{alu2_resp, alu2_req_id, alu2_data};
        if (!legal(alu2_resp)) m_err = 1;
        if (alu1_vld && alu1_req_id == alu2_req_id) skq.push_back(it);
        else del.push_back(it);
      end
    end
    foreach (del[i]) begin
      m_resp[del[i].id] = del[i].resp;
      m_data[del[i].id] = (del[i].resp != 0) ? del[i].data : 32'd0;
      dec[del[i].id]++;
    end
    if (iss1_vld) inc[iss1_req_id]++;
    if (iss2_vld) inc[iss2_req_id]++;
    for (int p = 0; p < 4; p++) begin
      sum = m_cnt[p] + inc[p];
      if (dec[p] > 0) begin
        if (sum == 0) m_err = 1;
        else sum = sum - 1;
      end
      if (sum > 3) begin
        m_err = 1;
        sum = 3;
      end
      m_cnt[p] = sum;
    end
  endtask

  task automatic check_all();
    bit exp_idle;
    exp_idle = (skq.size() == 0);
    for (int p = 0; p < 4; p++) begin
      if (m_cnt[p] != 0) exp_idle = 0;
      check_eq($sformatf("resp%0d", p), 64'(out_resp[p]), 64'(m_resp[p]));
      check_eq($sformatf("data%0d", p), 64'(out_data[p]), 64'(m_data[p]));
    end
    check_eq("stall", 64'(resp_stall), 64'(skq.size() != 0));
    check_eq("proto_err", 64'(proto_err), 64'(m_err));
    check_eq("idle", 64'(idle), 64'(exp_idle));
  endtask

  task automatic cycle();
    model_step();
    @(posedge c_clk);
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    reset_n = 0;
    drive_idle();
    #1;
    for (int p = 0; p < 4; p++) begin
      check_eq("rst_resp", 64'(out_resp[p]), 64'd0);
      check_eq("rst_data", 64'(out_data[p]), 64'd0);
    end
    check_eq("rst_stall", 64'(resp_stall), 64'd0);
    check_eq("rst_err", 64'(proto_err), 64'd0);
    model_reset();
    @(negedge c_clk);
    reset_n = 1;
    check_all();
  endtask

  task automatic set_alu1(input int id, input logic [1:0] r, input logic [31:0] d);
    alu1_vld = 1; alu1_req_id = 2'(id); alu1_resp = r; alu1_data = d;
  endtask

  task automatic set_alu2(input int id, input logic [1:0] r, input logic [31:0] d);
    alu2_vld = 1; alu2_req_id = 2'(id); alu2_resp = r; alu2_data = d;
  endtask

  task automatic set_iss(input int id1, input bit v2, input int id2);
    iss1_vld = 1; iss1_req_id = 2'(id1);
    iss2_vld = v2; iss2_req_id = 2'(id2);
  endtask

  // Legal traffic only: results go to ports with outstanding issues, no counter overflow.
  task automatic gen_legal();
    int av [4];
    int ic [4];
    int id;
    drive_idle();
    for (int p = 0; p < 4; p++) begin
      av[p] = m_cnt[p]; ic[p] = m_cnt[p];
    end
    foreach (skq[i]) av[skq[i].id]--;
    if (skq.size() == 0) begin
      id = $urandom_range(3, 0);
      if ($urandom_range(3, 0) != 0 && av[id] > 0) begin
        set_alu1(id, $urandom_range(1, 0) ? 2'b01 : 2'b10, $urandom);
        av[id]--;
      end
      id = $urandom_range(3, 0);
      if ($urandom_range(3, 0) != 0 && av[id] > 0) begin
        set_alu2(id, $urandom_range(1, 0) ? 2'b01 : 2'b10, $urandom);
        av[id]--;
      end
    end
    id = $urandom_range(3, 0);
    if ($urandom_range(1, 0) != 0 && ic[id] < 3) begin
      iss1_vld = 1; iss1_req_id = 2'(id); ic[id]++;
    end
    id = $urandom_range(3, 0);
    if ($urandom_range(1, 0) != 0 && ic[id] < 3) begin
      iss2_vld = 1; iss2_req_id = 2'(id); ic[id]++;
    end
  endtask

  initial begin
    drive_idle();
    #3;
    apply_reset();
    check_eq("reset_idle", 64'(idle), 64'd1);

    // Single result to id 2
    drive_idle(); set_iss(2, 0, 0); cycle();
    drive_idle(); set_alu1(2, 2'b01, 32'h5); cycle();
    check_eq("single_resp", 64'(out_resp[2]), 64'd1);
    check_eq("single_data", 64'(out_data[2]), 64'd5);
    check_eq("single_idle", 64'(idle), 64'd1);
    drive_idle(); cycle();
    check_eq("single_clear", 64'(out_resp[2]), 64'd0);

    // Different-port pair
    drive_idle(); set_iss(0, 1, 3); cycle();
    drive_idle(); set_alu1(0, 2'b01, 32'h7); set_alu2(3, 2'b01, 32'h80); cycle();
    check_eq("pair_resp1", 64'(out_resp[0]), 64'd1);
    check_eq("pair_resp4", 64'(out_resp[3]), 64'd1);
    check_eq("pair_data4", 64'(out_data[3]), 64'h80);
    check_eq("pair_stall", 64'(resp_stall), 64'd0);

    // Same-port collision
    drive_idle(); set_iss(1, 1, 1); cycle();
    drive_idle(); set_alu1(1, 2'b01, 32'hA); set_alu2(1, 2'b01, 32'hB); cycle();
    check_eq("coll_first", 64'(out_data[1]), 64'hA);
    check_eq("coll_stall", 64'(resp_stall), 64'd1);
    drive_idle(); cycle();
    check_eq("coll_second", 64'(out_data[1]), 64'hB);
    check_eq("coll_unstall", 64'(resp_stall), 64'd0);
    check_eq("coll_err", 64'(proto_err), 64'd0);

    // Stall violation: strobe during resp_stall is dropped
    drive_idle(); set_iss(1, 1, 1); cycle();
    drive_idle(); set_iss(2, 0, 0); cycle();
    drive_idle(); set_alu1(1, 2'b01, 32'h1); set_alu2(1, 2'b10, 32'h2); cycle();
    drive_idle(); set_alu1(2, 2'b01, 32'h55); cycle();
    check_eq("stallv_err", 64'(proto_err), 64'd1);
    check_eq("stallv_drop", 64'(out_resp[2]), 64'd0);
    drive_idle(); cycle();
    check_eq("stallv_never", 64'(out_resp[2]), 64'd0);
    apply_reset();

    // Delivery with nothing outstanding
    drive_idle(); set_alu1(3, 2'b10, 32'h9); cycle();
    check_eq("udf_resp", 64'(out_resp[3]), 64'd2);
    check_eq("udf_err", 64'(proto_err), 64'd1);
    apply_reset();

    // Four issues to port 0 saturate at 3
    drive_idle(); set_iss(0, 1, 0); cycle();
    drive_idle(); set_iss(0, 1, 0); cycle();
    check_eq("ovf_err", 64'(proto_err), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive_idle(); set_alu1(0, 2'b01, 32'(i)); cycle();
      check_eq("ovf_idle", 64'(idle), (i == 2) ? 64'd1 : 64'd0);
    end
    apply_reset();

    // Reset with skid full
    drive_idle(); set_iss(1, 1, 1); cycle();
    drive_idle(); set_alu1(1, 2'b01, 32'hC); set_alu2(1, 2'b01, 32'hD); cycle();
    check_eq("skid_full", 64'(resp_stall), 64'd1);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_idle(); cycle();
      check_eq("no_stale", 64'(out_resp[1]), 64'd0);
    end
    check_eq("post_rst_idle", 64'(idle), 64'd1);

    // Random legal traffic
    for (int i = 0; i < 400; i++) begin
      gen_legal(); cycle();
    end
    drive_idle();
    for (int i = 0; i < 2; i++) cycle();
    check_eq("legal_no_err", 64'(proto_err), 64'd0);

    // Unconstrained traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(49, 0) == 0) apply_reset();
      drive_idle();
      iss1_vld = 1'($urandom_range(1, 0)); iss1_req_id = 2'($urandom_range(3, 0));
      iss2_vld = 1'($urandom_range(1, 0)); iss2_req_id = 2'($urandom_range(3, 0));
      if ($urandom_range(2, 0) == 0) set_alu1($urandom_range(3, 0), 2'($urandom_range(3, 0)), $urandom);
      if ($urandom_range(2, 0) == 0) set_alu2($urandom_range(3, 0), 2'($urandom_range(3, 0)), $urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
